// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, the NOP word and the reset vector
// that the PC register and the fetch sequencer must agree on.
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_EXEC,
    S_BRANCH,
    S_HALT,
    S_FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the PC-control, instruction-fetch and execute-stage signals around the
// fetch sequencer; master is the sequencer side, slave is its environment.
interface fetch_sequencer_if;

  logic [31:0] pc_value;
  logic [31:0] pc_data;
  logic        pc_write_enable;
  logic        pc_write_add;
  logic        pc_count_enable;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_taken;
  logic        branch_relative;
  logic [31:0] branch_target;
  logic        halt_req;
  logic        fetch_fault;

  modport master (
    input  pc_value, mem_ack, mem_rdata, exec_done, branch_taken,
           branch_relative, branch_target, halt_req,
    output pc_data, pc_write_enable, pc_write_add, pc_count_enable,
           mem_req, mem_addr, instr, instr_valid, fetch_fault
  );

  modport slave (
    output pc_value, mem_ack, mem_rdata, exec_done, branch_taken,
           branch_relative, branch_target, halt_req,
    input  pc_data, pc_write_enable, pc_write_add, pc_count_enable,
           mem_req, mem_addr, instr, instr_valid, fetch_fault
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts fetch-wait cycles; o_tc flags the last cycle the sequencer may wait for an ack.
module fetch_timeout_ctr #(
  parameter int LIMIT = 16,
  parameter int W     = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  logic [W-1:0] r_count;

  // NOTE: non-blocking assignments so every register updates together on the edge.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_tc) begin
      r_count <= r_count + W'(1);
    end
  end

  // Terminal count is the LIMIT-th waiting cycle: the next increment would reach LIMIT.
  assign o_tc = (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues one fetch per instruction, latches it for decode
// and drives the PC count/load strobes after execute.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR   = cpu_pkg::RESET_VECTOR,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          TMO_W          = 5
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  import cpu_pkg::*;

  fetch_state_t r_state;
  fetch_state_t w_next;
  logic [31:0]  r_instr;
  logic [31:0]  r_br_target;
  logic         r_br_rel;
  logic         r_count_en;
  logic         r_fault;
  logic         w_tc;
  logic         w_fetch_ack;
  logic         w_take_branch;

  assign w_fetch_ack   = (r_state == S_FETCH) && bus.mem_ack;
  assign w_take_branch = (r_state == S_EXEC) && bus.exec_done && bus.branch_taken;

  fetch_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TMO_W)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .i_clear ((r_state != S_FETCH) || bus.mem_ack),
    .i_inc   (r_state == S_FETCH),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: the default assignment first means no path through the case can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:   w_next = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack)  w_next = S_EXEC;
        else if (w_tc)    w_next = S_FAULT;
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          if (bus.branch_taken)  w_next = S_BRANCH;
          else if (bus.halt_req) w_next = S_HALT;
          else                   w_next = S_FETCH;
        end
      end
      S_BRANCH: w_next = bus.halt_req ? S_HALT : S_FETCH;
      S_HALT:   if (!bus.halt_req) w_next = S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_BOOT;
    endcase
  end

  // The count-up strobe is registered so it fires in the first EXEC cycle, never with a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr     <= NOP_INSTR;
      r_count_en  <= 1'b0;
      r_fault     <= 1'b0;
      r_br_target <= '0;
      r_br_rel    <= 1'b0;
    end else begin
      r_count_en <= w_fetch_ack;
      if (w_fetch_ack) begin
        r_instr <= bus.mem_rdata;
      end
      if ((r_state == S_FETCH) && !bus.mem_ack && w_tc) begin
        r_fault <= 1'b1;
      end
      if (w_take_branch) begin
        r_br_target <= bus.branch_target;
        r_br_rel    <= bus.branch_relative;
      end
    end
  end

  assign bus.mem_req         = (r_state == S_FETCH);
  assign bus.mem_addr        = bus.pc_value;
  assign bus.instr           = r_instr;
  assign bus.instr_valid     = (r_state == S_EXEC);
  assign bus.pc_count_enable = r_count_en;
  assign bus.pc_write_enable = (r_state == S_BRANCH);
  assign bus.pc_write_add    = (r_state == S_BRANCH) && r_br_rel;
  assign bus.pc_data         = r_br_target;
  assign bus.fetch_fault     = r_fault;

  // The boot cycle exists so the PC settles at the reset vector before the first fetch.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_BOOT)) begin
      boot_pc_at_vector: assert (bus.pc_value == RESET_VECTOR);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus hand-written
// timeout, halt and sticky-fault sequences against a behavioural PC register.
module tb_fetch_sequencer;

  localparam logic [31:0] RV  = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;
  localparam int          TMO = 16;

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        done;
    logic        br;
    logic        rel;
    logic [31:0] tgt;
    logic        halt;
  } in_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        valid;
    logic        cnt;
    logic        we;
    logic        wadd;
    logic [31:0] pdata;
    logic        fault;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk;
  logic reset;
  logic [31:0] r_pc;
  int n_vec;
  int n_err;
  int n_both;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_VECTOR   (RV),
    .TIMEOUT_CYCLES (TMO),
    .TMO_W          (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PC register the sequencer steers.
  always @(posedge clk) begin
    if (reset)                     r_pc <= RV;
    else if (bus.pc_write_enable)  r_pc <= bus.pc_write_add ? (r_pc + bus.pc_data - 32'd4) : bus.pc_data;
    else if (bus.pc_count_enable)  r_pc <= r_pc + 32'd4;
  end
  assign bus.pc_value = r_pc;

  always @(negedge clk) begin
    if (bus.pc_write_enable && bus.pc_count_enable) n_both++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, ack, input logic [31:0] rdata,
                              input logic done, br, rel, input logic [31:0] tgt,
                              input logic halt, req, input logic [31:0] addr, instr,
                              input logic valid, cnt, we, wadd, input logic [31:0] pdata);
    vec_t v;
    v.i.rst   = rst;   v.i.ack   = ack;   v.i.rdata = rdata; v.i.done = done;
    v.i.br    = br;    v.i.rel   = rel;   v.i.tgt   = tgt;   v.i.halt = halt;
    v.o.req   = req;   v.o.addr  = addr;  v.o.instr = instr; v.o.valid = valid;
    v.o.cnt   = cnt;   v.o.we    = we;    v.o.wadd  = wadd;  v.o.pdata = pdata;
    v.o.fault = 1'b0;
    return v;
  endfunction

  function automatic out_t sample();
    out_t s;
    s.req   = bus.mem_req;         s.addr  = bus.mem_addr;
    s.instr = bus.instr;           s.valid = bus.instr_valid;
    s.cnt   = bus.pc_count_enable; s.we    = bus.pc_write_enable;
    s.wadd  = bus.pc_write_add;    s.pdata = bus.pc_data;
    s.fault = bus.fetch_fault;
    return s;
  endfunction

  task automatic drive(input in_t v);
    reset               = v.rst;
    bus.mem_ack         = v.ack;
    bus.mem_rdata       = v.rdata;
    bus.exec_done       = v.done;
    bus.branch_taken    = v.br;
    bus.branch_relative = v.rel;
    bus.branch_target   = v.tgt;
    bus.halt_req        = v.halt;
  endtask

  task automatic idle_inputs();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.exec_done = 1'b0; bus.branch_taken = 1'b0;
    bus.branch_relative = 1'b0; bus.branch_target = '0; bus.halt_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_req(input string name);
    for (int c = 0; c < 8 && !bus.mem_req; c++) @(negedge clk);
    check(name, 128'(bus.mem_req), 128'(H));
  endtask

  vec_t tbl[$];
  out_t act, exp;
  int   n_hi;
  int   n_halt_req;

  initial begin
    n_vec = 0; n_err = 0; n_both = 0;
    reset = 1'b1;
    idle_inputs();

    //                rst ack rdata         done br rel tgt           halt req addr          instr         val cnt we wadd pdata
    tbl.push_back(mk(H, L, Z,            L, L, L, Z,            L,  L, Z,            NOP,          L, L, L, L, Z));
    tbl.push_back(mk(L, L, Z,            L, L, L, Z,            L,  L, Z,            NOP,          L, L, L, L, Z));
    tbl.push_back(mk(L, L, Z,            L, L, L, Z,            L,  H, 32'h80000000, NOP,          L, L, L, L, Z));
    tbl.push_back(mk(L, L, Z,            L, L, L, Z,            L,  H, 32'h80000000, NOP,          L, L, L, L, Z));
    tbl.push_back(mk(L, H, 32'hA1A1A1A1, L, L, L, Z,            L,  H, 32'h80000000, NOP,          L, L, L, L, Z));
    tbl.push_back(mk(L, L, Z,            H, L, L, Z,            L,  L, Z,            32'hA1A1A1A1, H, H, L, L, Z));
    tbl.push_back(mk(L, H, 32'hA2A2A2A2, L, L, L, Z,            L,  H, 32'h80000004, 32'hA1A1A1A1, L, L, L, L, Z));
    tbl.push_back(mk(L, L, Z,            H, L, L, Z,            L,  L, Z,            32'hA2A2A2A2, H, H, L, L, Z));
    tbl.push_back(mk(L, H, 32'hA3A3A3A3, L, L, L, Z,            L,  H, 32'h80000008, 32'hA2A2A2A2, L, L, L, L, Z));
    tbl.push_back(mk(L, L, Z,            L, L, L, Z,            L,  L, Z,            32'hA3A3A3A3, H, H, L, L, Z));
    tbl.push_back(mk(L, L, Z,            H, L, L, Z,            L,  L, Z,            32'hA3A3A3A3, H, L, L, L, Z));
    tbl.push_back(mk(H, L, Z,            L, L, L, Z,            L,  H, 32'h8000000C, 32'hA3A3A3A3, L, L, L, L, Z));
    tbl.push_back(mk(L, H, 32'hDEADBEEF, L, L, L, Z,            L,  L, Z,            NOP,          L, L, L, L, Z));
    tbl.push_back(mk(L, H, 32'hB1B1B1B1, L, L, L, Z,            L,  H, 32'h80000000, NOP,          L, L, L, L, Z));
    tbl.push_back(mk(L, L, Z,            H, L, L, Z,            L,  L, Z,            32'hB1B1B1B1, H, H, L, L, Z));
    tbl.push_back(mk(L, H, 32'hB2B2B2B2, L, L, L, Z,            L,  H, 32'h80000004, 32'hB1B1B1B1, L, L, L, L, Z));
    tbl.push_back(mk(L, L, Z,            H, H, H, 32'hFFFFFFF8, L,  L, Z,            32'hB2B2B2B2, H, H, L, L, Z));
    tbl.push_back(mk(L, L, Z,            L, L, L, Z,            L,  L, Z,            32'hB2B2B2B2, L, L, H, H, 32'hFFFFFFF8));
    tbl.push_back(mk(L, H, 32'hB3B3B3B3, L, L, L, Z,            L,  H, 32'h7FFFFFFC, 32'hB2B2B2B2, L, L, L, L, 32'hFFFFFFF8));
    tbl.push_back(mk(L, L, Z,            H, H, L, 32'h80000100, L,  L, Z,            32'hB3B3B3B3, H, H, L, L, 32'hFFFFFFF8));
    tbl.push_back(mk(L, L, Z,            L, L, L, Z,            L,  L, Z,            32'hB3B3B3B3, L, L, H, L, 32'h80000100));
    tbl.push_back(mk(L, H, 32'hB4B4B4B4, L, L, L, Z,            L,  H, 32'h80000100, 32'hB3B3B3B3, L, L, L, L, 32'h80000100));
    tbl.push_back(mk(L, L, Z,            H, L, L, Z,            L,  L, Z,            32'hB4B4B4B4, H, H, L, L, 32'h80000100));
    tbl.push_back(mk(L, H, 32'hB5B5B5B5, L, L, L, Z,            L,  H, 32'h80000104, 32'hB4B4B4B4, L, L, L, L, 32'h80000100));
    tbl.push_back(mk(L, L, Z,            H, H, L, 32'h80000200, H,  L, Z,            32'hB5B5B5B5, H, H, L, L, 32'h80000100));
    tbl.push_back(mk(L, L, Z,            L, L, L, Z,            H,  L, Z,            32'hB5B5B5B5, L, L, H, L, 32'h80000200));
    tbl.push_back(mk(L, L, Z,            L, L, L, Z,            L,  L, Z,            32'hB5B5B5B5, L, L, L, L, 32'h80000200));
    tbl.push_back(mk(L, L, Z,            L, L, L, Z,            L,  H, 32'h80000200, 32'hB5B5B5B5, L, L, L, L, 32'h80000200));

    // Each row: outputs expected in this cycle, then the inputs for this cycle.
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      act = sample();
      exp = tbl[k].o;
      if (!exp.req) begin
        act.addr = '0;
        exp.addr = '0;
      end
      check($sformatf("vec%0d", k), 128'(act), 128'(exp));
      drive(tbl[k].i);
    end

    // Ack withheld: mem_req stays up for exactly TMO cycles, then a sticky fault.
    do_reset();
    wait_req("tmo_req_rise");
    n_hi = 0;
    for (int c = 0; c < 40 && bus.mem_req; c++) begin
      n_hi++;
      @(negedge clk);
    end
    check("tmo_req_cycles", 128'(n_hi), 128'(TMO));
    check("tmo_fault_set", 128'(bus.fetch_fault), 128'(H));
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("tmo_fault_sticky", 128'({bus.fetch_fault, bus.mem_req, bus.instr_valid, bus.pc_count_enable}),
          128'(4'b1000));
    check("tmo_instr_kept", 128'(bus.instr), 128'(NOP));
    do_reset();
    check("tmo_fault_cleared", 128'(bus.fetch_fault), 128'(L));

    // Ack arriving on the limit cycle wins over the timeout.
    wait_req("lim_req_rise");
    repeat (TMO - 1) @(negedge clk);
    check("lim_req_still_high", 128'(bus.mem_req), 128'(H));
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hC1C1C1C1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("lim_no_fault", 128'({bus.fetch_fault, bus.instr_valid, bus.pc_count_enable}), 128'(3'b011));
    check("lim_instr", 128'(bus.instr), 128'(32'hC1C1C1C1));

    // Halt after retiring: no fetch for 5 cycles, then resume at the next PC.
    bus.exec_done = 1'b1;
    bus.halt_req  = 1'b1;
    @(negedge clk);
    bus.exec_done = 1'b0;
    n_halt_req = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.mem_req || bus.instr_valid || bus.pc_write_enable) n_halt_req++;
      @(negedge clk);
    end
    check("halt_quiet_cycles", 128'(n_halt_req), 128'(0));
    bus.halt_req = 1'b0;
    @(negedge clk);
    check("halt_resume", 128'({bus.mem_req, bus.mem_addr}), 128'({H, 32'h80000004}));

    check("strobe_exclusion", 128'(n_both), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
